div_issue_ctrl: RTL and testbench

//  Upstream sequencer for the div_top sequential divider. Buffers operand pairs (x,y) in a small

---
 rtl/div_pkg.sv | 16 +
 rtl/div_op_fifo.sv | 52 +++++
 rtl/div_top.sv | 68 ++++++
 rtl/div_issue_ctrl.sv | 147 ++++++++++++++
 tb/tb_div_issue_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the divider issue controller.
package div_pkg;

  localparam int DIV_W       = 4;
  localparam int DIV_DEPTH   = 4;
  localparam int DIV_TIMEOUT = 64;
  localparam int DIV_TO_W    = $clog2(DIV_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/div_op_fifo.sv
// Operand-pair FIFO with show-ahead head; push and pop may coincide even when full.
module div_op_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers are exactly log2(DEPTH) bits, so wrap is implicit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/div_top.sv
// Restoring sequential divider: W iterations after go, then done held high until next go.
module div_top import div_pkg::*; #(
  parameter int W = DIV_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         go,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         done,
  output logic         error,
  output logic [W-1:0] q,
  output logic [W-1:0] r
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [W:0]    trial;
  logic [W:0]    diff;

  assign trial = {rem_q, quo_q[W-1]};
  assign diff  = trial - {1'b0, dvs_q};
  assign done  = done_q;
  assign error = err_q;
  assign q     = quo_q;
  assign r     = rem_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (go) begin
      quo_q  <= x;
      rem_q  <= '0;
      dvs_q  <= y;
      cnt_q  <= CW'(W);
      busy_q <= 1'b1;
      done_q <= 1'b0;
      err_q  <= (y == '0);
    end else if (busy_q) begin
      if (trial >= {1'b0, dvs_q}) begin
        rem_q <= diff[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b1};
      end else begin
        rem_q <= trial[W-1:0];
        quo_q <= {quo_q[W-2:0], 1'b0};
      end
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Feeds queued operand pairs to the sequential divider one at a time and returns
// results in order on a valid/ready port, aborting any op that never completes.
module div_issue_ctrl import div_pkg::*; #(
  parameter int W       = DIV_W,
  parameter int DEPTH   = DIV_DEPTH,
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  output logic         div_go,
  output logic [W-1:0] div_x,
  output logic [W-1:0] div_y,
  input  logic         div_done,
  input  logic         div_error,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [W-1:0] out_r,
  output logic         out_error,
  output logic         out_timeout,
  output logic         busy
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e         state_q;
  logic           div_go_q;
  logic [W-1:0]   div_x_q;
  logic [W-1:0]   div_y_q;
  logic           out_valid_q;
  logic [W-1:0]   out_q_q;
  logic [W-1:0]   out_r_q;
  logic           out_error_q;
  logic           out_timeout_q;
  logic           done_d_q;
  logic [CW-1:0]  cnt_q;

  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  logic [2*W-1:0] fifo_head;
  logic           done_rise;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & ~fifo_full;
  assign fifo_pop  = ~fifo_empty &
                     ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  // Only a fresh rising edge counts, so a done level left over from the last op is ignored.
  assign done_rise = div_done & ~done_d_q;
  assign busy      = (state_q != IDLE) | ~fifo_empty;

  assign div_go      = div_go_q;
  assign div_x       = div_x_q;
  assign div_y       = div_y_q;
  assign out_valid   = out_valid_q;
  assign out_q       = out_q_q;
  assign out_r       = out_r_q;
  assign out_error   = out_error_q;
  assign out_timeout = out_timeout_q;

  div_op_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (fifo_push),
    .wdata ({in_x, in_y}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      div_go_q      <= 1'b0;
      div_x_q       <= '0;
      div_y_q       <= '0;
      out_valid_q   <= 1'b0;
      out_q_q       <= '0;
      out_r_q       <= '0;
      out_error_q   <= 1'b0;
      out_timeout_q <= 1'b0;
      done_d_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      done_d_q <= div_done;
      div_go_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            div_x_q  <= fifo_head[2*W-1:W];
            div_y_q  <= fifo_head[W-1:0];
            div_go_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (done_rise) begin
            out_q_q       <= div_q;
            out_r_q       <= div_r;
            out_error_q   <= div_error;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= HOLD;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            out_q_q       <= '0;
            out_r_q       <= '0;
            out_error_q   <= 1'b0;
            out_timeout_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (!fifo_empty) begin
              div_x_q  <= fifo_head[2*W-1:W];
              div_y_q  <= fifo_head[W-1:0];
              div_go_q <= 1'b1;
              state_q  <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl driving the real div_top (with an optional stuck-done stub).
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int W  = DIV_W;
  localparam int TO = DIV_TIMEOUT;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid, in_ready;
  logic [W-1:0] in_x, in_y;
  logic         div_go;
  logic [W-1:0] div_x, div_y;
  logic         dt_done, ctrl_done, div_error;
  logic [W-1:0] div_q, div_r;
  logic         out_valid, out_ready;
  logic [W-1:0] out_q, out_r;
  logic         out_error, out_timeout, busy;
  logic         stub;
  bit           stall_en;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int go_count = 0;
  int last_go_cyc = 0;

  always #5 CLK = ~CLK;
  assign ctrl_done = dt_done & ~stub;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (div_go === 1'b1) begin
    go_count++;
    last_go_cyc = cyc;
  end

  div_issue_ctrl dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .div_go(div_go), .div_x(div_x), .div_y(div_y),
    .div_done(ctrl_done), .div_error(div_error), .div_q(div_q), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_error(out_error), .out_timeout(out_timeout), .busy(busy)
  );

  div_top u_div (
    .CLK(CLK), .RST(RST), .go(div_go), .x(div_x), .y(div_y),
    .done(dt_done), .error(div_error), .q(div_q), .r(div_r)
  );

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
    int b = 0;
    @(negedge CLK);
    in_valid = 1'b1; in_x = x; in_y = y;
    while (!in_ready && b < 500) begin
      @(negedge CLK);
      b++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_wait x=%0d y=%0d: in_ready stayed 0, required 1", x, y);
      in_valid = 1'b0;
    end else begin
      @(posedge CLK); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic get_result(output logic [W-1:0] q, output logic [W-1:0] r,
                            output logic e, output logic t);
    int b = 0;
    q = '0; r = '0; e = 1'b0; t = 1'b0;
    @(negedge CLK);
    while (!out_valid && b < 400) begin
      @(negedge CLK);
      b++;
    end
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("FAIL result_wait: out_valid stayed 0, required 1");
      t = 1'bx;
      return;
    end
    if (stall_en) repeat ($urandom_range(0, 3)) @(negedge CLK);
    q = out_q; r = out_r; e = out_error; t = out_timeout;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({out_valid, div_go, busy, out_error, out_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got valid/go/busy/err/to=%b required 00000",
               {out_valid, div_go, busy, out_error, out_timeout});
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    n_tests++;
    if ({out_q, out_r, div_x, div_y} !== '0) begin
      n_fail++; $display("FAIL reset_data got q=%0d r=%0d x=%0d y=%0d required 0",
                         out_q, out_r, div_x, div_y);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] q, r; logic e, t; int g0;
    g0 = go_count;
    push(4'd13, 4'd4);
    get_result(q, r, e, t);
    n_tests++;
    if ({q, r, e, t} !== {4'd3, 4'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL basic_13_4 got q=%0d r=%0d e=%b t=%b required q=3 r=1 e=0 t=0",
                         q, r, e, t);
    end
    n_tests++;
    if (go_count - g0 !== 1) begin
      n_fail++; $display("FAIL basic_go_count got %0d required 1", go_count - g0);
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic e, t;
    push(4'd9, 4'd0);
    get_result(q, r, e, t);
    n_tests++;
    if ({e, t} !== 2'b10) begin
      n_fail++; $display("FAIL div0_flags got e=%b t=%b required e=1 t=0", e, t);
    end
    push(4'd15, 4'd5);
    get_result(q, r, e, t);
    n_tests++;
    if ({q, r, e, t} !== {4'd3, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL after_div0_15_5 got q=%0d r=%0d e=%b t=%b required q=3 r=0 e=0 t=0",
                         q, r, e, t);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q, r; logic e, t;
    logic [2*W+1:0] snap;
    logic unstable;
    int g0, b;
    logic [W-1:0] exp_q [5];
    logic [W-1:0] exp_r [5];
    exp_q = '{4'd3, 4'd2, 4'd2, 4'd2, 4'd1};
    exp_r = '{4'd2, 4'd4, 4'd2, 4'd0, 4'd6};
    out_ready = 1'b0;
    g0 = go_count;
    for (int i = 0; i < 5; i++) push(4'd14, W'(4 + i));
    @(negedge CLK);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_full_in_ready got %b required 0", in_ready);
    end
    b = 0;
    while (!out_valid && b < 100) begin
      @(negedge CLK);
      b++;
    end
    snap = {out_q, out_r, out_error, out_timeout};
    unstable = !out_valid;
    repeat (50) begin
      @(negedge CLK);
      if (!out_valid || {out_q, out_r, out_error, out_timeout} !== snap) unstable = 1'b1;
    end
    n_tests++;
    if (unstable !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold_stable got unstable=%b required 0", unstable);
    end
    n_tests++;
    if (go_count - g0 !== 1) begin
      n_fail++; $display("FAIL bp_single_go got %0d required 1", go_count - g0);
    end
    for (int i = 0; i < 5; i++) begin
      get_result(q, r, e, t);
      n_tests++;
      if ({q, r, e, t} !== {exp_q[i], exp_r[i], 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL bp_order[%0d] got q=%0d r=%0d e=%b t=%b required q=%0d r=%0d e=0 t=0",
                           i, q, r, e, t, exp_q[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] q, r; logic e, t; int b, valid_cyc;
    stub = 1'b1;
    push(4'd13, 4'd4);
    b = 0;
    while (!out_valid && b < 200) begin
      @(negedge CLK);
      b++;
    end
    valid_cyc = cyc;
    n_tests++;
    if (valid_cyc - last_go_cyc !== TO + 1) begin
      n_fail++; $display("FAIL timeout_latency got %0d cycles required %0d",
                         valid_cyc - last_go_cyc, TO + 1);
    end
    get_result(q, r, e, t);
    n_tests++;
    if ({q, r, e, t} !== {4'd0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL timeout_result got q=%0d r=%0d e=%b t=%b required q=0 r=0 e=0 t=1",
                         q, r, e, t);
    end
    stub = 1'b0;
    repeat (10) @(negedge CLK);
  endtask

  task automatic test_reset_mid_op();
    int g0, g1;
    out_ready = 1'b0;
    g0 = go_count;
    for (int i = 0; i < 3; i++) push(4'd12, 4'd3);
    @(negedge CLK);
    n_tests++;
    if (go_count - g0 !== 1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_setup got go=%0d busy=%b required go=1 busy=1",
                         go_count - g0, busy);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    n_tests++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++; $display("FAIL rst_mid_op got valid/busy/in_ready=%b required 001",
                         {out_valid, busy, in_ready});
    end
    g1 = go_count;
    repeat (20) @(negedge CLK);
    n_tests++;
    if (go_count !== g1) begin
      n_fail++; $display("FAIL rst_no_go got %0d extra pulses required 0", go_count - g1);
    end
  endtask

  task automatic test_sweep();
    stall_en = 1'b1;
    fork
      begin
        for (int x = 7; x <= 15; x++)
          for (int y = 0; y <= 15; y++) push(W'(x), W'(y));
      end
      begin
        logic [W-1:0] q, r; logic e, t;
        for (int x = 7; x <= 15; x++)
          for (int y = 0; y <= 15; y++) begin
            get_result(q, r, e, t);
            n_tests++;
            if (y == 0) begin
              if ({e, t} !== 2'b10) begin
                n_fail++; $display("FAIL sweep x=%0d y=0 got e=%b t=%b required e=1 t=0", x, e, t);
              end
            end else if ({q, r, e, t} !== {W'(x / y), W'(x % y), 1'b0, 1'b0}) begin
              n_fail++; $display("FAIL sweep x=%0d y=%0d got q=%0d r=%0d e=%b t=%b required q=%0d r=%0d e=0 t=0",
                                 x, y, q, r, e, t, x / y, x % y);
            end
          end
      end
    join
    stall_en = 1'b0;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
    out_ready = 1'b0; stub = 1'b0; stall_en = 1'b0;
    test_reset();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
